// File: rtl/edge_detect_pkg.sv
// Shared encodings and 3x3 kernel weights for the edge detection engine.
package edge_detect_pkg;

    typedef enum logic [1:0] {
        MODE_SOBEL       = 2'b00,
        MODE_PREWITT     = 2'b01,
        MODE_BIN_SOBEL   = 2'b10,
        MODE_BIN_PREWITT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic signed [2:0] coef_t;
    typedef coef_t kern_t [3][3];

    // Indexed [row][col], row 0 on top, col 0 on the left.
    localparam kern_t SOBEL_X = '{
        '{-3'sd1, 3'sd0, 3'sd1},
        '{-3'sd2, 3'sd0, 3'sd2},
        '{-3'sd1, 3'sd0, 3'sd1}
    };
    localparam kern_t SOBEL_Y = '{
        '{-3'sd1, -3'sd2, -3'sd1},
        '{ 3'sd0,  3'sd0,  3'sd0},
        '{ 3'sd1,  3'sd2,  3'sd1}
    };
    localparam kern_t PREWITT_X = '{
        '{-3'sd1, 3'sd0, 3'sd1},
        '{-3'sd1, 3'sd0, 3'sd1},
        '{-3'sd1, 3'sd0, 3'sd1}
    };
    localparam kern_t PREWITT_Y = '{
        '{-3'sd1, -3'sd1, -3'sd1},
        '{ 3'sd0,  3'sd0,  3'sd0},
        '{ 3'sd1,  3'sd1,  3'sd1}
    };

endpackage

// File: rtl/line_buffer.sv
// Enabled shift-register delay line; q_o is the sample pushed DEPTH shifts ago.
module line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] taps_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            taps_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                taps_q[k] <= taps_q[k-1];
            end
        end
    end

    assign q_o = taps_q[DEPTH-1];

endmodule

// File: rtl/edge_detect_engine.sv
// Streaming 3x3 Sobel/Prewitt gradient-magnitude engine between a
// start/busy/done controller and a 1-cycle-latency pixel RAM.
module edge_detect_engine
    import edge_detect_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk_50M,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [PIX_W-1:0]  threshold,
    input  logic [ADDR_W-1:0] addr_in_base,
    input  logic [ADDR_W-1:0] addr_out_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int LAST  = NPIX + IMG_W + 3;
    localparam int CNT_W = $clog2(LAST + 1);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int GW    = PIX_W + 3;
    localparam int MW    = PIX_W + 4;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RUN_END = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] CNT_CMP_BEG = CNT_W'(IMG_W + 3);
    localparam logic [CNT_W-1:0] CNT_CMP_END = CNT_W'(NPIX + IMG_W + 2);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(LAST);
    localparam logic [CW-1:0]    COL_LAST    = CW'(IMG_W - 1);
    localparam logic [RW-1:0]    ROW_LAST    = RW'(IMG_H - 1);
    localparam logic [PIX_W-1:0] PIX_MAX     = '1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    mode_e               mode_q;
    logic [PIX_W-1:0]    thr_q;
    logic [ADDR_W-1:0]   in_base_q;
    logic [ADDR_W-1:0]   optr_q;
    logic                rd_vld_q;
    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [PIX_W-1:0]    wr_data_q;
    logic [PIX_W-1:0]    win_q [3][3];

    logic                active;
    logic                cmp_en;
    logic [PIX_W-1:0]    feed;
    logic [PIX_W-1:0]    lb0_out;
    logic [PIX_W-1:0]    lb1_out;
    logic signed [GW-1:0] gx, gy, px, kx, ky;
    logic [GW-1:0]       ax, ay;
    logic [MW-1:0]       mag;
    logic [PIX_W-1:0]    sat_pix, bin_pix, pix_d;
    logic                prewitt, binary, border;

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                rd_en   = 1'b1;
                rd_addr = in_base_q + ADDR_W'(cnt_q);
                busy    = 1'b1;
                if (cnt_q == CNT_RUN_END) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign active = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign cmp_en = active && (cnt_q >= CNT_CMP_BEG)
                           && (cnt_q <= CNT_CMP_END);

    // Once reads stop, zeros are pushed in to drain the last rows.
    assign feed = rd_vld_q ? rd_data : '0;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk_i (clk_50M),
        .en_i  (active),
        .d_i   (feed),
        .q_o   (lb0_out)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk_i (clk_50M),
        .en_i  (active),
        .d_i   (lb0_out),
        .q_o   (lb1_out)
    );

    always_ff @(posedge clk_50M) begin
        if (active) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_out;
            win_q[1][2] <= lb0_out;
            win_q[2][2] <= feed;
        end
    end

    always_comb begin
        prewitt = (mode_q == MODE_PREWITT) || (mode_q == MODE_BIN_PREWITT);
        binary  = (mode_q == MODE_BIN_SOBEL) || (mode_q == MODE_BIN_PREWITT);
        gx = '0;
        gy = '0;
        px = '0;
        kx = '0;
        ky = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                px = $signed({3'b000, win_q[r][c]});
                kx = GW'(prewitt ? PREWITT_X[r][c] : SOBEL_X[r][c]);
                ky = GW'(prewitt ? PREWITT_Y[r][c] : SOBEL_Y[r][c]);
                gx = gx + kx * px;
                gy = gy + ky * px;
            end
        end
        ax = gx[GW-1] ? GW'(-gx) : GW'(gx);
        ay = gy[GW-1] ? GW'(-gy) : GW'(gy);
        mag = {1'b0, ax} + {1'b0, ay};
        sat_pix = (mag > MW'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
        bin_pix = (mag >= {4'b0000, thr_q}) ? PIX_MAX : '0;
        border = (col_q == '0) || (col_q == COL_LAST)
              || (row_q == '0) || (row_q == ROW_LAST);
        pix_d = border ? '0 : (binary ? bin_pix : sat_pix);
    end

    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= MODE_SOBEL;
            thr_q     <= '0;
            in_base_q <= '0;
            optr_q    <= '0;
            rd_vld_q  <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_en;
            wr_en_q  <= cmp_en;
            if (state_q == ST_IDLE && start) begin
                mode_q    <= mode_e'(mode);
                thr_q     <= threshold;
                in_base_q <= addr_in_base;
                optr_q    <= addr_out_base;
                cnt_q     <= '0;
                col_q     <= '0;
                row_q     <= '0;
            end else if (active) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (cmp_en) begin
                wr_addr_q <= optr_q;
                wr_data_q <= pix_d;
                optr_q    <= optr_q + ADDR_W'(1);
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_edge_detect_engine.sv
// Bench for edge_detect_engine: directed table, random frames vs a
// neighbourhood-arithmetic model, and reset/start corner sequences.
module tb_edge_detect_engine;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;
    localparam int BOUND = 150;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  threshold;
    logic [11:0] addr_in_base;
    logic [11:0] addr_out_base;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;

    always #10 clk = ~clk;

    edge_detect_engine #(
        .IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(12)
    ) dut (
        .clk_50M       (clk),
        .reset         (reset),
        .start         (start),
        .mode          (mode),
        .threshold     (threshold),
        .addr_in_base  (addr_in_base),
        .addr_out_base (addr_out_base),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done)
    );

    logic [7:0] mem [4096];

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    typedef struct {
        int lo;
        int hi;
        int md;
        int thr;
        int inb;
        int outb;
        int edge_v;
    } vec_t;

    vec_t vt [8];

    int n_chk = 0;
    int n_fail = 0;
    int img [N];
    int exp_img [N];
    int outv [4096];
    int wcnt [4096];
    int wr_n, first_wr, last_wr, done_cyc, done_n;
    int busy_n, rd_n, rd_bad, wr_after;
    int snap_ctl, snap_bus;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic int px(input int r, input int c);
        return img[r*W + c];
    endfunction

    function automatic int ref_pix(input int r, input int c,
                                   input int md, input int thr);
        int wc, gx, gy, mag;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
        wc = (md == 1 || md == 3) ? 1 : 2;
        gx = (px(r-1,c+1) + wc*px(r,c+1) + px(r+1,c+1))
           - (px(r-1,c-1) + wc*px(r,c-1) + px(r+1,c-1));
        gy = (px(r+1,c-1) + wc*px(r+1,c) + px(r+1,c+1))
           - (px(r-1,c-1) + wc*px(r-1,c) + px(r-1,c+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (md >= 2) return (mag >= thr) ? 255 : 0;
        return (mag > 255) ? 255 : mag;
    endfunction

    task automatic load_image(input int inb);
        for (int j = 0; j < N; j++) mem[(inb + j) % 4096] = 8'(img[j]);
    endtask

    task automatic step_image(input int lo, input int hi, input int ev);
        for (int j = 0; j < N; j++) begin
            int r, c;
            r = j / W;
            c = j % W;
            img[j] = (c < 4) ? lo : hi;
            exp_img[j] = (r > 0 && r < H-1 && (c == 3 || c == 4)) ? ev : 0;
        end
    endtask

    task automatic run_frame(input int md, input int thr, input int inb,
                             input int outb, input int rst_at,
                             input int restart_at);
        for (int a = 0; a < 4096; a++) begin
            outv[a] = -1;
            wcnt[a] = 0;
        end
        mode = 2'(md);
        threshold = 8'(thr);
        addr_in_base = 12'(inb);
        addr_out_base = 12'(outb);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        mode = mode ^ 2'b01;
        threshold = ~threshold;
        addr_in_base = addr_in_base ^ 12'h555;
        addr_out_base = addr_out_base ^ 12'h2AA;
        wr_n = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
        done_n = 0; busy_n = 0; rd_n = 0; rd_bad = 0; wr_after = 0;
        snap_ctl = -1; snap_bus = -1;
        for (int k = 0; k < BOUND; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (rd_en) begin
                rd_n++;
                if (int'(rd_addr) != (inb + k) % 4096) rd_bad++;
            end
            if (wr_en) begin
                wr_n++;
                if (first_wr < 0) first_wr = k;
                last_wr = k;
                outv[wr_addr] = int'(wr_data);
                wcnt[wr_addr]++;
                if (rst_at >= 0 && k >= rst_at) wr_after++;
            end
            if (k == rst_at) begin
                snap_ctl = int'({rd_en, wr_en, busy, done});
                snap_bus = int'(rd_addr) + int'(wr_addr) + int'(wr_data);
            end
            start = (k == restart_at);
            reset = !(k == rst_at - 1);
            @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b1;
    endtask

    task automatic check_frame(input int outb, input string tag);
        int bad, once, fj, fa, fe;
        chk({tag, "/writes"}, wr_n, N);
        chk({tag, "/first_wr_cycle"}, first_wr, W + 4);
        chk({tag, "/last_wr_cycle"}, last_wr, N + W + 3);
        chk({tag, "/done_cycle"}, done_cyc, N + W + 4);
        chk({tag, "/done_pulses"}, done_n, 1);
        chk({tag, "/busy_cycles"}, busy_n, N + W + 4);
        chk({tag, "/reads"}, rd_n, N);
        chk({tag, "/rd_addr_bad"}, rd_bad, 0);
        bad = 0; once = 0; fj = -1; fa = 0; fe = 0;
        for (int j = 0; j < N; j++) begin
            int a;
            a = (outb + j) % 4096;
            if (wcnt[a] == 1) once++;
            if (outv[a] != exp_img[j]) begin
                if (fj < 0) begin
                    fj = j; fa = outv[a]; fe = exp_img[j];
                end
                bad++;
            end
        end
        chk({tag, "/written_once"}, once, N);
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s/pixels: %0d wrong, first j=%0d got %0d expected %0d",
                     tag, bad, fj, fa, fe);
        end
    endtask

    initial begin
        int busy_seen, rd_seen;
        vt[0] = '{100, 100, 0,   0, 'h000, 'h100,   0};
        vt[1] = '{  0,  40, 0,   0, 'h000, 'h100, 160};
        vt[2] = '{  0,  40, 1,   0, 'h000, 'h100, 120};
        vt[3] = '{  0,  40, 2, 150, 'h000, 'h100, 255};
        vt[4] = '{  0,  40, 2, 161, 'h000, 'h100,   0};
        vt[5] = '{  0, 255, 0,   0, 'h000, 'h100, 255};
        vt[6] = '{  0,  40, 0,   0, 'hFFC, 'h100, 160};
        vt[7] = '{  0,  40, 3, 120, 'h200, 'hFF0, 255};

        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        reset = 1'b0;
        start = 1'b0;
        mode = 2'b00;
        threshold = 8'h00;
        addr_in_base = 12'h000;
        addr_out_base = 12'h000;
        repeat (3) @(negedge clk);
        chk("reset/ctl", int'({rd_en, wr_en, busy, done}), 0);
        chk("reset/bus", int'(rd_addr) + int'(wr_addr) + int'(wr_data), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            step_image(vt[t].lo, vt[t].hi, vt[t].edge_v);
            load_image(vt[t].inb);
            run_frame(vt[t].md, vt[t].thr, vt[t].inb, vt[t].outb, -1, -1);
            check_frame(vt[t].outb, $sformatf("vec%0d", t));
        end

        for (int f = 0; f < 5; f++) begin
            int md, thr, inb, outb;
            md = int'($urandom_range(0, 3));
            thr = int'($urandom_range(0, 255));
            inb = int'($urandom_range(0, 4095));
            outb = int'($urandom_range(0, 4095));
            for (int j = 0; j < N; j++) img[j] = int'($urandom_range(0, 63));
            for (int j = 0; j < N; j++)
                exp_img[j] = ref_pix(j / W, j % W, md, thr);
            load_image(inb);
            run_frame(md, thr, inb, outb, -1, -1);
            check_frame(outb, $sformatf("rand%0d_m%0d", f, md));
        end

        step_image(0, 40, 160);
        load_image(0);
        run_frame(0, 0, 0, 'h100, 20, -1);
        chk("midreset/ctl_at_edge", snap_ctl, 0);
        chk("midreset/bus_at_edge", snap_bus, 0);
        chk("midreset/done_pulses", done_n, 0);
        chk("midreset/writes_after", wr_after, 0);
        chk("midreset/busy_end", int'(busy), 0);

        run_frame(0, 0, 0, 'h100, -1, 30);
        check_frame('h100, "start_in_busy");

        @(negedge clk);
        mode = 2'b00;
        start = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        busy_seen = 0;
        rd_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy) busy_seen++;
            if (rd_en) rd_seen++;
            @(negedge clk);
        end
        chk("start_reset/busy", busy_seen, 0);
        chk("start_reset/rd_en", rd_seen, 0);
        run_frame(1, 0, 0, 'h300, -1, -1);
        step_image(0, 40, 120);
        check_frame('h300, "after_start_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
